// File: rtl/sr_semaphore_if.sv
// sr_semaphore_if: request/acknowledge bundle between requesters (master) and the semaphore (slave)
//   req[3:0]   per-requester request strobe
//   op[3:0]    per-requester operation, 1 = acquire, 0 = release
//   gnt[3:0]   one-hot one-cycle acknowledge
//   busy       semaphore flag, 1 while locked
//   owner[1:0] index of current holder
//   sr[1:0]    latch drive code: 01 set, 10 reset, 11 hold
//   err        one-cycle pulse on an illegal release
//   timeout    one-cycle pulse on a forced release
interface sr_semaphore_if;
    logic [3:0] req;
    logic [3:0] op;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
    logic [1:0] sr;
    logic       err;
    logic       timeout;
    modport master (output req, op, input gnt, busy, owner, sr, err, timeout);
    modport slave  (input req, op, output gnt, busy, owner, sr, err, timeout);
endinterface

// File: rtl/sr_semaphore_ctrl.sv
// sr_semaphore_ctrl: 4-requester round-robin semaphore driving an SR-latch style set/reset code
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   sr_semaphore_if.slave: req/op in; gnt/busy/owner/sr/err/timeout out (all registered)
//   HOLD_MAX: locked cycles before a forced release, 0 disables the timeout
module sr_semaphore_ctrl #(
    parameter int HOLD_MAX = 255
) (
    input logic           clk,
    input logic           rst_n,
    sr_semaphore_if.slave bus
);
    typedef enum logic {FREE, LOCKED} state_t;
    state_t     state, state_n;
    logic [3:0] acq, rel, gnt_n;
    logic [1:0] rr_ptr, rr_n, win, owner_n, sr_n;
    logic [7:0] hold_cnt, hold_n;
    logic       err_n, to_n;
    assign acq = bus.req & bus.op;
    assign rel = bus.req & ~bus.op;
    // descending scan so the acquirer closest above rr_ptr is the last one written
    always_comb begin
        win = rr_ptr;
        for (int k = 3; k >= 0; k--)
            if (acq[rr_ptr + 2'(k)]) win = rr_ptr + 2'(k);
    end
    always_comb begin
        state_n = state;
        gnt_n   = 4'b0000;
        owner_n = bus.owner;
        sr_n    = 2'b11;
        err_n   = 1'b0;
        to_n    = 1'b0;
        rr_n    = rr_ptr;
        hold_n  = hold_cnt;
        if (state == FREE) begin
            err_n = |rel;
            if (|acq) begin
                state_n = LOCKED;
                gnt_n   = 4'b0001 << win;
                owner_n = win;
                sr_n    = 2'b01;
                hold_n  = 8'd0;
                rr_n    = win + 2'd1;
            end
        end else begin
            // acquires are ignored while locked; only releases matter here
            err_n = |(rel & ~(4'b0001 << bus.owner));
            if (rel[bus.owner]) begin
                state_n = FREE;
                gnt_n   = 4'b0001 << bus.owner;
                sr_n    = 2'b10;
            end else if (HOLD_MAX != 0 && hold_cnt == 8'(HOLD_MAX)) begin
                state_n = FREE;
                sr_n    = 2'b10;
                to_n    = 1'b1;
            end else begin
                hold_n = hold_cnt + {7'd0, hold_cnt != 8'hff};
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FREE;
            rr_ptr      <= 2'd0;
            hold_cnt    <= 8'd0;
            bus.gnt     <= 4'b0000;
            bus.busy    <= 1'b0;
            bus.owner   <= 2'd0;
            bus.sr      <= 2'b10;
            bus.err     <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_n;
            hold_cnt    <= hold_n;
            bus.gnt     <= gnt_n;
            bus.busy    <= state_n == LOCKED;
            bus.owner   <= owner_n;
            bus.sr      <= sr_n;
            bus.err     <= err_n;
            bus.timeout <= to_n;
        end
    end
endmodule
